scan_sequencer: RTL and testbench

- Frame-scan controller for the 32x32 virtual-bot camera image held in pixel memory.
- On a start request it latches the bot orientation and maps it to one of four scan orders.
- It then issues all 1024 pixel addresses in that order over a valid/ready handshake to the memory read port, flags the final beat, and pulses done.
- It sits between the orientation/steering logic and the image memory, and replaces per-orientation counter selection with a single sequenced source.

---
 rtl/scan_pkg.sv | 33 +++
 rtl/scan_addr_map.sv | 29 ++
 rtl/scan_sequencer.sv | 125 ++++++++++++
 tb/tb_scan_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the frame-scan sequencer: image geometry,
// FSM states, scan orders and the orientation-to-scan-order mapping.
package scan_pkg;

  localparam int DIM_LOG2 = 5;
  localparam int SIDE     = 1 << DIM_LOG2;
  localparam int FRAME    = SIDE * SIDE;
  localparam int AW       = 2 * DIM_LOG2;

  typedef logic [DIM_LOG2-1:0] idx_t;
  typedef logic [AW-1:0]       addr_t;

  localparam idx_t  IDX_ZERO = idx_t'(0);
  localparam idx_t  IDX_ONE  = idx_t'(1);
  localparam idx_t  IDX_MAX  = idx_t'(SIDE - 1);
  localparam addr_t ADDR_MAX = addr_t'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {M0, M1, M2, M3} scan_mode_t;

  // Each scan order serves a pair of adjacent 45-degree orientations.
  function automatic scan_mode_t orient_to_mode(input logic [2:0] orient);
    scan_mode_t m;
    case (orient)
      3'd0, 3'd1: m = M0;
      3'd2, 3'd3: m = M1;
      3'd4, 3'd5: m = M2;
      default:    m = M3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/scan_addr_map.sv
// Maps (scan order, outer index, inner index) to a pixel address; purely
// combinational, no state and no flow control.
module scan_addr_map
  import scan_pkg::*;
(
  input  scan_mode_t mode_i,
  input  idx_t       o_i,
  input  idx_t       i_i,
  output addr_t      addr_o
);

  addr_t row_major;
  addr_t col_major;

  assign row_major = {o_i, i_i};
  assign col_major = {i_i, o_i};

  always_comb begin
    addr_o = row_major;
    case (mode_i)
      M0:      addr_o = row_major;
      M1:      addr_o = col_major;
      M2:      addr_o = ADDR_MAX - row_major;
      M3:      addr_o = {i_i, IDX_MAX - o_i};
      default: addr_o = row_major;
    endcase
  end

endmodule

// File: rtl/scan_sequencer.sv
// Issues all 1024 pixel addresses in an orientation-dependent order, one beat per
// accepted handshake starting the cycle after start; addr/last hold while ready is low.
module scan_sequencer
  import scan_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    orient,
  input  logic          addr_ready,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
  output logic          addr_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    mode
);

  state_t     state_q;
  scan_mode_t mode_q, mode_d;
  idx_t       o_q, o_d;
  idx_t       i_q, i_d;
  addr_t      addr_q;
  logic       valid_q, last_q, busy_q, done_q;
  addr_t      map_addr;
  logic       hs;

  assign hs = valid_q & addr_ready;

  // Indices of the beat that will be presented after this edge; the address is
  // mapped from them so that the output register always holds the current beat.
  always_comb begin
    mode_d = mode_q;
    o_d    = IDX_ZERO;
    i_d    = IDX_ZERO;
    if (state_q == IDLE) begin
      mode_d = orient_to_mode(orient);
    end else begin
      i_d = i_q + IDX_ONE;
      o_d = (i_q == IDX_MAX) ? o_q + IDX_ONE : o_q;
    end
  end

  scan_addr_map u_map (
    .mode_i (mode_d),
    .o_i    (o_d),
    .i_i    (i_d),
    .addr_o (map_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= M0;
      o_q     <= IDX_ZERO;
      i_q     <= IDX_ZERO;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            state_q <= SCAN;
            mode_q  <= mode_d;
            o_q     <= IDX_ZERO;
            i_q     <= IDX_ZERO;
            addr_q  <= map_addr;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (abort) begin
            state_q <= IDLE;
            o_q     <= IDX_ZERO;
            i_q     <= IDX_ZERO;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (hs) begin
            if (last_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              o_q    <= o_d;
              i_q    <= i_d;
              addr_q <= map_addr;
              last_q <= (o_d == IDX_MAX) && (i_d == IDX_MAX);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          o_q     <= IDX_ZERO;
          i_q     <= IDX_ZERO;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign addr_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: table-driven full frames against a
// scoreboard queue, plus hand-written abort, reset and ignored-start sequences.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, addr_ready;
  logic [2:0] orient;
  logic [9:0] addr;
  logic       addr_valid, addr_last, busy, done;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] sb_q[$];

  typedef struct {
    logic [2:0] orient;
    bit         toggle;
    bit         poke;
    logic [1:0] exp_mode;
    int         spot_beat;
    logic [9:0] spot_addr;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  scan_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .orient     (orient),
    .addr_ready (addr_ready),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_last  (addr_last),
    .busy       (busy),
    .done       (done),
    .mode       (mode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {last, addr} of beat k for a scan order, from the row/column definitions.
  function automatic logic [10:0] exp_beat(input logic [1:0] m, input int k);
    int o, i, a;
    o = k / 32;
    i = k % 32;
    case (m)
      2'd0:    a = o * 32 + i;
      2'd1:    a = i * 32 + o;
      2'd2:    a = 1023 - (o * 32 + i);
      default: a = i * 32 + (31 - o);
    endcase
    return {(k == 1023), a[9:0]};
  endfunction

  task automatic push_frame(input logic [1:0] m);
    sb_q.delete();
    for (int k = 0; k < 1024; k++) sb_q.push_back(exp_beat(m, k));
  endtask

  task automatic begin_scan(input logic [2:0] o, input logic [1:0] m);
    push_frame(m);
    @(negedge clk);
    orient = o;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("first_valid", {31'd0, addr_valid}, 32'd1);
    check("mode_latched", {30'd0, mode}, {30'd0, m});
  endtask

  // Runs n beats with ready held high, comparing each against the scoreboard.
  task automatic run_beats(input int n);
    int beat;
    beat = 0;
    addr_ready = 1'b1;
    while (beat < n && sb_q.size() > 0) begin
      check("beat_addr", {21'd0, addr_last, addr}, {21'd0, sb_q[0]});
      void'(sb_q.pop_front());
      beat++;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int beat, cyc;
    begin_scan(v.orient, v.exp_mode);
    beat = 0;
    cyc  = 0;
    while (beat < 1024 && cyc < 4000) begin
      addr_ready = v.toggle ? ((cyc % 2) == 1) : 1'b1;
      if (v.poke && beat == 10) begin
        start  = 1'b1;
        orient = ~v.orient;
      end else begin
        start = 1'b0;
      end
      check("valid_held", {31'd0, addr_valid}, 32'd1);
      check("frame_addr", {21'd0, addr_last, addr}, {21'd0, sb_q[0]});
      if (addr_ready) begin
        if (beat == v.spot_beat) check("spot_addr", {22'd0, addr}, {22'd0, v.spot_addr});
        void'(sb_q.pop_front());
        beat++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (beat < 1024) begin
      check("frame_timeout", beat, 1024);
      sb_q.delete();
    end
    if (!v.toggle) check("beat_cycles", cyc, 1024);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_valid", {31'd0, addr_valid}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("mode_kept", {30'd0, mode}, {30'd0, v.exp_mode});
    if (v.poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_once", {31'd0, done}, 32'd0);
    check("idle_valid", {31'd0, addr_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("no_restart", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{3'd0, 1'b0, 1'b0, 2'd0, 1023, 10'd1023};
    tbl[1] = '{3'd6, 1'b0, 1'b0, 2'd3,   32, 10'd30};
    tbl[2] = '{3'd7, 1'b1, 1'b1, 2'd3,    3, 10'd127};
    tbl[3] = '{3'd3, 1'b0, 1'b0, 2'd1,   32, 10'd1};
    tbl[4] = '{3'd4, 1'b0, 1'b1, 2'd2, 1023, 10'd0};
    tbl[5] = '{3'd0, 1'b1, 1'b0, 2'd0,  500, 10'd500};
    tbl[6] = '{3'd6, 1'b0, 1'b0, 2'd3, 1023, 10'd992};

    reset = 1'b1; start = 1'b0; abort = 1'b0; orient = 3'd0; addr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", {22'd0, addr}, 32'd0);
    check("rst_valid", {31'd0, addr_valid}, 32'd0);
    check("rst_last", {31'd0, addr_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mode", {30'd0, mode}, 32'd0);
    reset = 1'b0;

    for (int t = 0; t < 7; t++) run_frame(tbl[t]);

    // Abort concurrent with a ready beat: no done, and a fresh start begins at beat 0.
    begin_scan(3'd0, 2'd0);
    run_beats(100);
    abort = 1'b1;
    addr_ready = 1'b1;
    check("abort_beat", {22'd0, addr}, 32'd100);
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", {31'd0, addr_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    begin_scan(3'd2, 2'd1);
    run_beats(3);
    check("restart_beat3", {22'd0, addr}, 32'd96);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sb_q.delete();

    // Start with abort in IDLE stays idle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_valid", {31'd0, addr_valid}, 32'd0);
    check("start_abort_busy", {31'd0, busy}, 32'd0);

    // Reset mid-frame drops the rest of the scan.
    begin_scan(3'd4, 2'd2);
    run_beats(500);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_addr", {22'd0, addr}, 32'd0);
    check("midrst_valid", {31'd0, addr_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_mode", {30'd0, mode}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    sb_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
